// File: rtl/strobe_sync.sv
// Synchronises and deglitches asynchronous bus strobes, emitting clean levels, edge pulses
// and a data-bus capture qualified by the rising edge of one selected strobe channel.
module strobe_sync #(
  parameter int WIDTH       = 4,
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER      = 2,
  parameter int CAP_CH      = 0,
  parameter bit RESET_VAL   = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  din,
  input  logic [DATA_W-1:0] dbus,
  output logic [WIDTH-1:0]  q,
  output logic [WIDTH-1:0]  rise,
  output logic [WIDTH-1:0]  fall,
  output logic [DATA_W-1:0] cap_data,
  output logic              cap_valid
);

  localparam int CNT_W = $clog2(FILTER + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0]  din_sync;
  logic [SYNC_STAGES-1:0][DATA_W-1:0] dbus_sync;
  logic [WIDTH-1:0][CNT_W-1:0]        cnt;
  logic [WIDTH-1:0][CNT_W-1:0]        cnt_nxt;
  logic [WIDTH-1:0]                   s;
  logic [WIDTH-1:0]                   q_nxt;
  logic [DATA_W-1:0]                  sd;
  logic                               cap_hit;

  assign s  = din_sync[SYNC_STAGES-1];
  assign sd = dbus_sync[SYNC_STAGES-1];

  // A channel only follows s once the mismatch has persisted FILTER cycles.
  always_comb begin
    q_nxt   = q;
    cnt_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] != q[i]) begin
        if (cnt[i] == CNT_LAST) begin
          q_nxt[i] = s[i];
        end else begin
          cnt_nxt[i] = cnt[i] + 1'b1;
        end
      end
    end
  end

  assign cap_hit = q_nxt[CAP_CH] & ~q[CAP_CH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      din_sync  <= {(SYNC_STAGES * WIDTH){RESET_VAL}};
      dbus_sync <= {(SYNC_STAGES * DATA_W){RESET_VAL}};
      cnt       <= '0;
      q         <= {WIDTH{RESET_VAL}};
      rise      <= '0;
      fall      <= '0;
      cap_data  <= '0;
      cap_valid <= 1'b0;
    end else begin
      din_sync  <= {din_sync[SYNC_STAGES-2:0], din};
      dbus_sync <= {dbus_sync[SYNC_STAGES-2:0], dbus};
      cnt       <= cnt_nxt;
      q         <= q_nxt;
      rise      <= q_nxt & ~q;
      fall      <= ~q_nxt & q;
      cap_valid <= cap_hit;
      if (cap_hit) begin
        cap_data <= sd;
      end
    end
  end

endmodule

// File: tb/tb_strobe_sync.sv
// Directed bench for strobe_sync at default parameters: reset, latency, glitch rejection,
// data capture, multi-channel edges and reset during a pending filter count.
module tb_strobe_sync;

  logic       clock;
  logic       reset;
  logic [3:0] din;
  logic [7:0] dbus;
  logic [3:0] q;
  logic [3:0] rise;
  logic [3:0] fall;
  logic [7:0] cap_data;
  logic       cap_valid;

  int vectors = 0;
  int miscompares = 0;

  strobe_sync dut (
    .clock     (clock),
    .reset     (reset),
    .din       (din),
    .dbus      (dbus),
    .q         (q),
    .rise      (rise),
    .fall      (fall),
    .cap_data  (cap_data),
    .cap_valid (cap_valid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] eq, input logic [3:0] er,
                         input logic [3:0] ef, input logic [7:0] ed, input logic ev);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".rise"}, 32'(rise), 32'(er));
    chk({tag, ".fall"}, 32'(fall), 32'(ef));
    chk({tag, ".cap_data"}, 32'(cap_data), 32'(ed));
    chk({tag, ".cap_valid"}, 32'(cap_valid), 32'(ev));
  endtask

  initial begin
    // 1: outputs stay cleared while reset is held, whatever the inputs do
    reset = 1'b1;
    din   = 4'hF;
    dbus  = 8'hFF;
    #1;
    chk_all("rst_t0", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      chk_all("rst_hold", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    end
    din  = 4'h0;
    dbus = 8'h00;
    tick(3);
    reset = 1'b0;
    tick(6);
    chk_all("idle", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);

    // 2: single rising strobe, q follows after SYNC_STAGES+FILTER = 4 clocks
    din = 4'h1;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk("lat.q_pre", 32'(q), 32'h0);
      chk("lat.rise_pre", 32'(rise), 32'h0);
    end
    tick(1);
    chk_all("lat.edge4", 4'h1, 4'h1, 4'h0, 8'h00, 1'b1);
    tick(1);
    chk_all("lat.edge5", 4'h1, 4'h0, 4'h0, 8'h00, 1'b0);
    din = 4'h0;
    tick(4);
    chk("fall0.q", 32'(q), 32'h0);
    chk("fall0.fall", 32'(fall), 32'h1);
    tick(2);

    // 3: one-clock glitch on din[1] must never reach q
    din = 4'h2;
    tick(1);
    din = 4'h0;
    for (int k = 0; k < 8; k++) begin
      tick(1);
      chk_all("glitch", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    end

    // 4: capture of dbus on rise of channel 0, then hold while dbus changes
    dbus = 8'hA5;
    tick(3);
    din = 4'h1;
    tick(3);
    chk_all("cap.pre", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    tick(1);
    chk_all("cap.edge", 4'h1, 4'h1, 4'h0, 8'hA5, 1'b1);
    tick(1);
    chk_all("cap.after", 4'h1, 4'h0, 4'h0, 8'hA5, 1'b0);
    dbus = 8'h3C;
    tick(5);
    chk_all("cap.hold", 4'h1, 4'h0, 4'h0, 8'hA5, 1'b0);
    din = 4'h0;
    tick(6);
    chk("cap.fall_q", 32'(q), 32'h0);
    chk("cap.hold2", 32'(cap_data), 32'hA5);

    // 5: simultaneous edges on several channels
    din = 4'hF;
    tick(3);
    chk("multi.rise_pre", 32'(rise), 32'h0);
    tick(1);
    chk_all("multi.rise", 4'hF, 4'hF, 4'h0, 8'h3C, 1'b1);
    tick(1);
    chk("multi.rise_clr", 32'(rise), 32'h0);
    din = 4'h5;
    tick(4);
    chk_all("multi.fall", 4'h5, 4'h0, 4'hA, 8'h3C, 1'b0);
    tick(1);
    chk("multi.fall_clr", 32'(fall), 32'h0);

    // 6: reset during a pending count discards it; normal latency after release
    din = 4'h8;
    tick(6);
    chk("pre6.q", 32'(q), 32'h8);
    din = 4'hC;
    tick(3);
    reset = 1'b1;
    #1;
    chk_all("rst_async", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    tick(2);
    chk_all("rst_mid", 4'h0, 4'h0, 4'h0, 8'h00, 1'b0);
    reset = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      tick(1);
      chk("rel.q_pre", 32'(q), 32'h0);
      chk("rel.pulse_pre", 32'({rise, fall}), 32'h0);
    end
    tick(1);
    chk_all("rel.edge4", 4'hC, 4'hC, 4'h0, 8'h00, 1'b0);
    tick(1);
    chk("rel.rise_clr", 32'(rise), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
